// File: rtl/sipo_frame_pkg.sv
// Shared types for the SIPO frame controller: FSM state encoding and default word width.
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_shift_en.sv
// WIDTH-bit left-shift register with synchronous clear and shift enable.
// clr together with en starts a fresh word whose only bit is d_in.
module sipo_shift_en
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             d_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fresh;

  assign shifted[0] = d_in;
  assign fresh[0]   = d_in;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign shifted[gi] = q_q[gi-1];
      assign fresh[gi]   = 1'b0;
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = clr ? fresh : shifted;
    end else if (clr) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames a strobed serial bit stream into WIDTH-bit words behind a one-word valid/ready buffer.
// Optional even-parity bit after each word when SIPO_FRAME_PARITY_EN is defined.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             s_start,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_overrun,
  output logic             m_perr,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sh_clr;
  logic             sh_en;
  logic [WIDTH-1:0] sh_q;
  logic             last_bit;
  logic             complete;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             overrun_q, overrun_d;

  sipo_shift_en #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk (clk),
    .rst (rst),
    .clr (sh_clr),
    .en  (sh_en),
    .d_in(s_in),
    .q   (sh_q)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SIPO_FRAME_PARITY_EN
  logic word_perr;
  logic m_perr_q, m_perr_d;

  // The word is already fully shifted in while the parity bit is awaited.
  assign word = sh_q;
`else
  logic sh_msb_unused;

  // The word completes on the shift edge, so it is taken from the shifter input side.
  assign word          = {sh_q[WIDTH-2:0], s_in};
  assign sh_msb_unused = sh_q[WIDTH-1];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_clr   = 1'b0;
    sh_en    = 1'b0;
    complete = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
    word_perr = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (s_valid && s_start) begin
          sh_clr  = 1'b1;
          sh_en   = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (s_valid) begin
          sh_en = 1'b1;
          if (s_start) begin
            // Restart: the partial frame is discarded, this bit becomes bit 1.
            sh_clr = 1'b1;
            cnt_d  = CNT_W'(1);
          end else if (last_bit) begin
            cnt_d = CNT_W'(WIDTH);
`ifdef SIPO_FRAME_PARITY_EN
            state_d = PAR;
`else
            complete = 1'b1;
            state_d  = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SIPO_FRAME_PARITY_EN
      PAR: begin
        if (s_valid) begin
          if (s_start) begin
            sh_clr  = 1'b1;
            sh_en   = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end else begin
            complete  = 1'b1;
            word_perr = ^{sh_q, s_in};
            state_d   = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
    m_perr_d = m_perr_q;
`endif
    if (complete) begin
      // A word leaving this cycle frees the buffer for the new one.
      if (!m_valid_q || m_ready) begin
        m_data_d  = word;
        m_valid_d = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
        m_perr_d = word_perr;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SIPO_FRAME_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      m_perr_q <= 1'b0;
    end else begin
      m_perr_q <= m_perr_d;
    end
  end

  assign m_perr = m_perr_q;
`else
  assign m_perr = 1'b0;
`endif

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_overrun = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed scenarios plus a randomized run
// against a frame-level reference model (bit queue + one-word buffer).
module tb_sipo_frame_ctrl;

  localparam int WIDTH = 8;
`ifdef SIPO_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_in = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_start = 1'b0;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_overrun;
  logic             m_perr;
  logic             busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  bit               mq[$];
  bit               in_frame = 0;
  bit               par_phase = 0;
  logic [WIDTH-1:0] exp_data = '0;
  logic             exp_valid = 1'b0;
  logic             exp_perr = 1'b0;
  logic             exp_ovr = 1'b0;

  sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_in     (s_in),
    .s_valid  (s_valid),
    .s_start  (s_start),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_overrun(m_overrun),
    .m_perr   (m_perr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // One clock: the model absorbs the inputs present at the rising edge, outputs settle by #1.
  task automatic step();
    bit               done;
    int               ones;
    logic [WIDTH-1:0] w;
    done = 0;
    ones = 0;
    w    = '0;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      in_frame  = 0;
      par_phase = 0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_perr  = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      if (s_valid) begin
        if (s_start) begin
          mq.delete();
          mq.push_back(s_in);
          in_frame  = 1;
          par_phase = 0;
        end else if (in_frame && par_phase) begin
          done      = 1;
          ones      = int'(s_in);
          in_frame  = 0;
          par_phase = 0;
        end else if (in_frame) begin
          mq.push_back(s_in);
          if (mq.size() == WIDTH) begin
            if (PAR_EN) par_phase = 1;
            else begin
              done     = 1;
              in_frame = 0;
            end
          end
        end
      end
      if (done) begin
        foreach (mq[i]) begin
          w[WIDTH-1-i] = mq[i];
          ones += int'(mq[i]);
        end
      end
      exp_ovr = 1'b0;
      if (done) begin
        if (!exp_valid || m_ready) begin
          exp_valid = 1'b1;
          exp_data  = w;
          exp_perr  = PAR_EN && (ones % 2 == 1);
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && m_ready) begin
        exp_valid = 1'b0;
      end
    end
    #1;
  endtask

  // Optional idle gap cycles, then one strobed bit; rdy_ctl<0 leaves m_ready alone.
  task automatic send_bit(input logic b, input logic st, input int gap, input int rdy_ctl);
    repeat (gap) begin
      s_valid = 1'b0;
      s_start = 1'b0;
      s_in    = 1'($urandom);
      step();
    end
    if (rdy_ctl >= 0) m_ready = (rdy_ctl != 0);
    s_valid = 1'b1;
    s_start = st;
    s_in    = b;
    step();
    s_valid = 1'b0;
    s_start = 1'b0;
  endtask

  // Full frame (plus parity bit when enabled); rdy_ctl applies on the final strobe only.
  task automatic send_frame(input logic [WIDTH-1:0] w, input int gap, input int rdy_ctl,
                            input logic par);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(w[WIDTH-1-i], (i == 0), gap, (!PAR_EN && i == WIDTH - 1) ? rdy_ctl : -1);
    end
    if (PAR_EN) send_bit(par, 1'b0, gap, rdy_ctl);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 00", m_data); end
    n_cmp++; if (m_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", m_overrun); end
    n_cmp++; if (m_perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", m_perr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    step();
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    send_frame(8'hB2, 0, 1, 1'b0);
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'hB2) begin n_fail++; $display("FAIL basic_data: got %h want b2", m_data); end
    n_cmp++; if (m_perr !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", m_perr); end
    step();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b want 0", m_valid); end
    $display("test_basic: word %h", 8'hB2);
  endtask

  task automatic test_gapped();
    logic [WIDTH-1:0] w;
    int               nb;
    w       = 8'h5A;
    nb      = PAR_EN ? WIDTH + 1 : WIDTH;
    m_ready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      repeat (2) begin
        s_valid = 1'b0;
        s_start = 1'b1;
        s_in    = 1'($urandom);
        step();
        if (i > 0) begin
          n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy: bit %0d got %b want 1", i, busy); end
        end
      end
      s_valid = 1'b1;
      s_start = (i == 0);
      s_in    = (i < WIDTH) ? w[WIDTH-1-i] : 1'b0;
      step();
    end
    s_valid = 1'b0;
    s_start = 1'b0;
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'h5A) begin n_fail++; $display("FAIL gap_data: got %h want 5a", m_data); end
    step();
    $display("test_gapped: word %h", w);
  endtask

  task automatic test_overrun();
    m_ready = 1'b0;
    send_frame(8'h11, 0, 0, 1'b0);
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b want 1", m_valid); end
    send_frame(8'h22, 0, 0, 1'b0);
    n_cmp++; if (m_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b want 1", m_overrun); end
    n_cmp++; if (m_data !== 8'h11) begin n_fail++; $display("FAIL ovr_hold_data: got %h want 11", m_data); end
    step();
    n_cmp++; if (m_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle: got %b want 0", m_overrun); end
    n_cmp++; if (m_data !== 8'h11 || m_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_kept: got %h/%b want 11/1", m_data, m_valid); end
    m_ready = 1'b1;
    step();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got %b want 0", m_valid); end
    $display("test_overrun: kept %h dropped %h", 8'h11, 8'h22);
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    send_frame(8'h33, 1, 0, 1'b0);
    n_cmp++; if (m_data !== 8'h33) begin n_fail++; $display("FAIL b2b_first: got %h want 33", m_data); end
    send_frame(8'h44, 1, 1, 1'b0);
    n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'h44) begin n_fail++; $display("FAIL b2b_data: got %h want 44", m_data); end
    n_cmp++; if (m_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", m_overrun); end
    step();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", m_valid); end
    $display("test_back_to_back: %h then %h", 8'h33, 8'h44);
  endtask

  task automatic test_abort();
    logic [4:0] part;
    part    = 5'b10101;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(part[4-i], (i == 0), 0, -1);
    n_cmp++; if (m_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_partial: valid/busy %b/%b want 0/1", m_valid, busy); end
    send_frame(8'hC3, 0, 1, 1'b0);
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hC3) begin n_fail++; $display("FAIL abort_word: got %b/%h want 1/c3", m_valid, m_data); end
    step();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL abort_single: got %b want 0", m_valid); end
    $display("test_abort: restart word %h", 8'hC3);
  endtask

  task automatic test_rst_mid();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b1, (i == 0), 0, -1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({m_valid, m_overrun, m_perr, busy} !== 4'b0 || m_data !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got v%b o%b p%b b%b d%h want all 0", m_valid, m_overrun, m_perr, busy, m_data); end
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 0, -1);
    n_cmp++; if (m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tail: valid/busy %b/%b want 0/0", m_valid, busy); end
    m_ready = 1'b0;
    send_frame(8'h77, 0, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (m_valid !== 1'b0 || m_data !== '0) begin n_fail++; $display("FAIL rst_buffer: got %b/%h want 0/00", m_valid, m_data); end
    step();
    $display("test_rst_mid: done");
  endtask

`ifdef SIPO_FRAME_PARITY_EN
  task automatic test_parity();
    m_ready = 1'b1;
    for (int i = 0; i < WIDTH; i++) send_bit(1'(8'hB2 >> (WIDTH - 1 - i)), (i == 0), 0, -1);
    n_cmp++; if (m_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL par_wait: valid/busy %b/%b want 0/1", m_valid, busy); end
    send_bit(1'b0, 1'b0, 0, -1);
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hB2 || m_perr !== 1'b0) begin n_fail++; $display("FAIL par_good: got %b/%h/%b want 1/b2/0", m_valid, m_data, m_perr); end
    step();
    send_frame(8'hB2, 0, 1, 1'b1);
    n_cmp++; if (m_valid !== 1'b1 || m_perr !== 1'b1) begin n_fail++; $display("FAIL par_bad: valid/perr %b/%b want 1/1", m_valid, m_perr); end
    step();
    for (int i = 0; i < WIDTH; i++) send_bit(1'(8'hB2 >> (WIDTH - 1 - i)), (i == 0), 0, -1);
    send_frame(8'h0F, 0, 1, 1'b0);
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h0F || m_perr !== 1'b0) begin n_fail++; $display("FAIL par_abort: got %b/%h/%b want 1/0f/0", m_valid, m_data, m_perr); end
    step();
    $display("test_parity: done");
  endtask
`endif

  task automatic test_random();
    int errs_before;
    errs_before = n_fail;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_valid = 1'($urandom % 2);
      s_start = s_valid && ($urandom % 12 == 0);
      s_in    = 1'($urandom);
      m_ready = ((cyc / 64) % 2 == 1) ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
      rst     = ($urandom % 400 == 0);
      step();
      n_cmp++; if (m_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid: cyc %0d got %b want %b", cyc, m_valid, exp_valid); end
      n_cmp++; if (m_overrun !== exp_ovr) begin n_fail++; $display("FAIL rnd_overrun: cyc %0d got %b want %b", cyc, m_overrun, exp_ovr); end
      n_cmp++; if (busy !== logic'(in_frame)) begin n_fail++; $display("FAIL rnd_busy: cyc %0d got %b want %b", cyc, busy, in_frame); end
      if (exp_valid) begin
        n_cmp++; if (m_data !== exp_data) begin n_fail++; $display("FAIL rnd_data: cyc %0d got %h want %h", cyc, m_data, exp_data); end
        n_cmp++; if (m_perr !== exp_perr) begin n_fail++; $display("FAIL rnd_perr: cyc %0d got %b want %b", cyc, m_perr, exp_perr); end
      end
    end
    rst     = 1'b0;
    s_valid = 1'b0;
    s_start = 1'b0;
    $display("test_random: 3000 cycles, %0d new mismatches", n_fail - errs_before);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_rst_mid();
`ifdef SIPO_FRAME_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
